ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles to wait for mem_ack (range 2..255).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction substituted on timeout.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pc, input, 32: fetch address from the PC register.
REQ-006 SHALL have port fetch_req, input, 1: request a fetch of pc this cycle.
REQ-007 SHALL have port redirect, input, 1: jump or taken branch; flush the in-flight fetch.
REQ-008 SHALL have port mem_req, output, 1: memory read request.
REQ-009 SHALL have port mem_addr, output, 32: memory read address.
REQ-010 SHALL have port mem_ack, input, 1: memory read data valid.
REQ-011 SHALL have port mem_rdata, input, 32: memory read data.
REQ-012 SHALL have port instr, output, 32: fetched instruction.
REQ-013 SHALL have port instr_pc, output, 32: address of instr.
REQ-014 SHALL have port pc_plus_4, output, 32: instr_pc + 4, fed back to the PC register.
REQ-015 SHALL have port instr_valid, output, 1: instr, instr_pc and pc_plus_4 are valid.
REQ-016 SHALL have port instr_ready, input, 1: decode stage accepts instr.
REQ-017 SHALL have port stall, output, 1: a fetch_req cannot be accepted this cycle.
REQ-018 SHALL have port misalign, output, 1: one-cycle pulse when a rejected request has pc[1:0] != 0.
REQ-019 SHALL have port timeout_err, output, 1: one-cycle pulse when a fetch times out.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, DRAIN and VALID.
REQ-021 IDLE: fetch_req=1 with pc[1:0]=0 SHALL latch pc into instr_pc, drive mem_req=1 with mem_addr=pc on the next cycle, and go to WAIT.
REQ-022 IDLE: fetch_req=1 with pc[1:0]!=0 SHALL pulse misalign on the next cycle, issue no mem_req, and stay in IDLE.
REQ-023 WAIT SHALL hold mem_req=1 and mem_addr stable until mem_ack, and SHALL count wait cycles.
REQ-024 WAIT with mem_ack SHALL capture mem_rdata into instr, deassert mem_req, and go to VALID; latency from fetch_req to instr_valid SHALL be 2 cycles when mem_ack is returned in the first WAIT cycle.
REQ-025 WAIT with the count reaching TIMEOUT and no ack SHALL load instr=NOP_INSTR, pulse timeout_err, deassert mem_req, and go to VALID.
REQ-026 VALID SHALL hold instr_valid=1 and all output data stable until instr_valid and instr_ready are both 1.
REQ-027 On that VALID handshake, if fetch_req=1 with an aligned pc in the same cycle, the block SHALL go directly to WAIT with the new pc (back-to-back); otherwise it SHALL go to IDLE.
REQ-028 redirect in WAIT SHALL go to DRAIN; DRAIN SHALL keep mem_req=1 until mem_ack, discard mem_rdata, and then go to IDLE; no instr_valid SHALL be produced for a drained fetch.
REQ-029 redirect in VALID SHALL clear instr_valid on the next cycle and go to IDLE, even when instr_ready=1 in that cycle.
REQ-030 redirect in IDLE SHALL have no effect; redirect SHALL have priority over a fetch_req in the same cycle, except in IDLE.
REQ-031 stall SHALL equal fetch_req & (state is WAIT or DRAIN, or state is VALID without an instr_ready handshake).
REQ-032 pc_plus_4 SHALL be instr_pc + 4, computed modulo 2^32 (32'hFFFF_FFFC yields 0).
REQ-033 The timeout counter SHALL reset to 0 on every entry to WAIT; DRAIN SHALL NOT time out.

Reset
REQ-034 While rst_n=0, the block SHALL enter state IDLE asynchronously and hold all outputs at 0: mem_req, mem_addr, instr, instr_pc, pc_plus_4, instr_valid, stall, misalign and timeout_err.
REQ-035 Reset asserted mid-fetch SHALL abandon the fetch; no instr_valid SHALL follow release of reset.

Verification
REQ-036 pc=0x100 with fetch_req one cycle, mem_ack one cycle later with rdata 0x00500093 -> instr_valid two cycles after the request, instr=0x00500093, instr_pc=0x100, pc_plus_4=0x104.
REQ-037 Hold instr_ready=0 for 3 cycles in VALID -> outputs stable, stall=1 while fetch_req=1; a handshake with fetch_req and pc=0x104 -> mem_addr=0x104 on the next cycle.
REQ-038 pc=0x102 with fetch_req -> misalign pulses one cycle and mem_req stays 0.
REQ-039 No mem_ack for 16 cycles -> timeout_err pulses and instr=0x00000013.
REQ-040 redirect in WAIT, then mem_ack 2 cycles later -> no instr_valid, and the block is in IDLE the cycle after the ack.
REQ-041 pc=0xFFFFFFFC fetch -> pc_plus_4=0x00000000; rst_n pulled low while in WAIT -> mem_req=0 immediately.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one memory read per request, waits for the
// ack (with timeout), and presents the instruction to decode with a valid/ready handshake.
module ifetch_unit #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        redirect,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        stall,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  // Counter value on the last permitted wait cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        tout_q, tout_d;

  logic aligned_req_s;
  logic misaligned_req_s;
  logic handshake_s;

  assign aligned_req_s    = fetch_req & (pc[1:0] == 2'b00);
  assign misaligned_req_s = fetch_req & (pc[1:0] != 2'b00);
  assign handshake_s      = valid_q & instr_ready;

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    tout_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aligned_req_s) begin
          state_d    = S_WAIT;
          cnt_d      = 8'd0;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          instr_pc_d = pc;
          pc4_d      = pc + 32'd4;
        end else if (misaligned_req_s) begin
          misalign_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // An ack in the redirect cycle already retires the stale read.
          if (mem_ack) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (mem_ack) begin
          state_d   = S_VALID;
          instr_d   = mem_rdata;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_VALID;
          instr_d   = NOP_INSTR;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          tout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_VALID: begin
        if (redirect) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (handshake_s) begin
          valid_d = 1'b0;
          if (aligned_req_s) begin
            state_d    = S_WAIT;
            cnt_d      = 8'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
            instr_pc_d = pc;
            pc4_d      = pc + 32'd4;
          end else begin
            state_d    = S_IDLE;
            misalign_d = misaligned_req_s;
          end
        end else begin
          state_d = S_VALID;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      tout_q     <= tout_d;
    end
  end

  assign stall = fetch_req & ((state_q == S_WAIT) | (state_q == S_DRAIN) |
                              ((state_q == S_VALID) & ~handshake_s));

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus_4   = pc4_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: scoreboard of expected instructions
// popped on every decode handshake, plus directed checks of control outputs.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus_4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        stall;
  logic        misalign;
  logic        timeout_err;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ifetch_unit #(.TIMEOUT(16), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_req(fetch_req), .redirect(redirect),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_plus_4(pc_plus_4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .misalign(misalign), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] ipc);
    exp_t e;
    e.ins = ins;
    e.ipc = ipc;
    e.pc4 = ipc + 32'd4;
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", instr_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", instr, e.ins);
        check("sb_instr_pc", instr_pc, e.ipc);
        check("sb_pc_plus_4", pc_plus_4, e.pc4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_plus_4", pc_plus_4, 32'd0);
    check("rst_flags", {27'd0, instr_valid, stall, misalign, timeout_err, 1'b0}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic fetch with 2-cycle latency.
    pc = 32'h100; fetch_req = 1'b1;
    push(32'h0050_0093, 32'h100);
    cyc();
    fetch_req = 1'b0;
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_valid_early", 32'(instr_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    cyc();
    mem_ack = 1'b0;
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_mem_req_off", 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    check("t1_valid_clr", 32'(instr_valid), 32'd0);

    // Backpressure then back-to-back fetch.
    pc = 32'h200; fetch_req = 1'b1;
    push(32'hAABB_CCDD, 32'h200);
    cyc();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
    cyc();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    pc = 32'h104; fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall", 32'(stall), 32'd1);
      check("t2_hold_instr", instr, 32'hAABB_CCDD);
      check("t2_hold_pc", instr_pc, 32'h200);
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      cyc();
    end
    instr_ready = 1'b1;
    push(32'h1111_1111, 32'h104);
    #1;
    check("t2_hs_stall", 32'(stall), 32'd0);
    cyc();
    instr_ready = 1'b0; fetch_req = 1'b0;
    check("t2_b2b_req", 32'(mem_req), 32'd1);
    check("t2_b2b_addr", mem_addr, 32'h104);
    check("t2_b2b_valid", 32'(instr_valid), 32'd0);
    cyc();
    cyc();
    check("t2_addr_stable", mem_addr, 32'h104);
    check("t2_req_stable", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    cyc();
    mem_ack = 1'b0; instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;

    // Misaligned request.
    pc = 32'h102; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t3_misalign", 32'(misalign), 32'd1);
    check("t3_no_req", 32'(mem_req), 32'd0);
    cyc();
    check("t3_misalign_pulse", 32'(misalign), 32'd0);
    check("t3_no_req2", 32'(mem_req), 32'd0);

    // Timeout after 16 silent wait cycles.
    pc = 32'h300; fetch_req = 1'b1;
    push(32'h0000_0013, 32'h300);
    cyc();
    fetch_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      check("t4_no_timeout_yet", {30'd0, timeout_err, mem_req}, 32'd1);
    end
    cyc();
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    check("t4_nop", instr, 32'h0000_0013);
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_req_off", 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    check("t4_timeout_pulse", 32'(timeout_err), 32'd0);

    // Redirect during WAIT drains the fetch; any valid here would hit the scoreboard.
    instr_ready = 1'b1;
    pc = 32'h400; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0; redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    check("t5_drain_req", 32'(mem_req), 32'd1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    cyc();
    mem_ack = 1'b0;
    check("t5_no_valid", 32'(instr_valid), 32'd0);
    check("t5_req_off", 32'(mem_req), 32'd0);

    // Wrap-around of pc_plus_4; acceptance here also shows the block is idle.
    pc = 32'hFFFF_FFFC; fetch_req = 1'b1;
    push(32'h1234_5678, 32'hFFFF_FFFC);
    #1;
    check("t6_idle_no_stall", 32'(stall), 32'd0);
    cyc();
    fetch_req = 1'b0;
    check("t6_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    mem_ack = 1'b0;
    check("t6_pc_plus_4", pc_plus_4, 32'h0000_0000);
    cyc();
    instr_ready = 1'b0;

    // Reset asserted mid-fetch.
    pc = 32'h500; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t7_req_before_rst", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req_async_clr", 32'(mem_req), 32'd0);
    check("t7_addr_clr", mem_addr, 32'd0);
    cyc();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    cyc();
    mem_ack = 1'b0;
    cyc();
    check("t7_no_valid", 32'(instr_valid), 32'd0);
    check("t7_no_req", 32'(mem_req), 32'd0);

    // Redirect in VALID wins over a simultaneous handshake.
    pc = 32'h600; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    cyc();
    mem_ack = 1'b0;
    check("t8_valid", 32'(instr_valid), 32'd1);
    redirect = 1'b1; instr_ready = 1'b1;
    cyc();
    redirect = 1'b0; instr_ready = 1'b0;
    check("t8_valid_clr", 32'(instr_valid), 32'd0);
    check("t8_no_req", 32'(mem_req), 32'd0);

    cyc();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
